vend_dispense_sequencer: RTL and testbench

Sequences the physical actuators downstream of the coin-counting vending FSM. It accepts a one-cycle vend request (dispense flag plus 3-bit change count), drives the drink motor for a fixed time, then pulses the coin-return hopper once per coin owed. It refunds the full 5-cent price when the drink column is sold out, and holds coin acceptance inhibited while busy.

---
 rtl/vend_dispense_sequencer.sv | 213 +++++++++++++++++++++
 tb/tb_vend_dispense_sequencer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vend_dispense_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : vend_dispense_sequencer
// Description : Drives the physical actuators that sit after the coin-counting
//               vending FSM. A one-cycle vend request runs the drink motor for
//               a fixed time. The coin-return hopper is then pulsed once for
//               each coin owed. If the drink column is sold out, the full
//               5-cent price is refunded as coins instead of dispensing.
//               Coin acceptance stays inhibited while a sequence runs.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   MOTOR_CYCLES : cycles the motor is held high per drink       (1..255)
//   PULSE_CYCLES : cycles the hopper is high per ejected coin    (1..255)
//   GAP_CYCLES   : cycles the hopper is low between two coins    (1..255)
// Ports
//   clk          in   1  system clock, rising edge
//   reset        in   1  asynchronous active-high reset
//   d            in   1  dispense request (one-cycle pulse)
//   r            in   3  coins to return, valid together with the request
//   empty        in   1  drink column sold out, sampled with the request
//   motor        out  1  drink motor drive
//   hopper       out  1  hopper eject, one pulse per coin
//   busy         out  1  sequencer not idle
//   coin_inhibit out  1  coin slot blocked (same as busy)
//   done         out  1  one-cycle pulse at the end of a sequence
//   sold_out     out  1  one-cycle pulse when a dispense becomes a refund
//   overrun      out  1  one-cycle pulse when a request is dropped while busy
// ============================================================================
module vend_dispense_sequencer #(
    parameter int MOTOR_CYCLES = 4,
    parameter int PULSE_CYCLES = 2,
    parameter int GAP_CYCLES   = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       d,
    input  logic [2:0] r,
    input  logic       empty,
    output logic       motor,
    output logic       hopper,
    output logic       busy,
    output logic       coin_inhibit,
    output logic       done,
    output logic       sold_out,
    output logic       overrun
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_MOTOR = 3'd1,
        S_PULSE = 3'd2,
        S_GAP   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // Timer reload values: a phase of N cycles counts N-1 down to 0.
    localparam logic [7:0] c_MOTOR_RELOAD = 8'(MOTOR_CYCLES - 1);
    localparam logic [7:0] c_PULSE_RELOAD = 8'(PULSE_CYCLES - 1);
    localparam logic [7:0] c_GAP_RELOAD   = 8'(GAP_CYCLES - 1);

    // Refund added to the coin count when the column is sold out.
    localparam logic [3:0] c_PRICE_COINS  = 4'd5;

    // ------------------------------------------------------------------------
    // Registers and next-state values
    // ------------------------------------------------------------------------
    state_t     state_q,    state_d;
    logic [7:0] timer_q,    timer_d;
    logic [3:0] count_q,    count_d;
    logic       sold_out_q, sold_out_d;
    logic       overrun_q,  overrun_d;
    logic       motor_q;
    logic       hopper_q;
    logic       busy_q;
    logic       done_q;

    logic       w_req;
    logic [3:0] w_load_count;
    logic [3:0] w_count_dec;
    logic [7:0] w_timer_dec;

    // A request is either a dispense or a pure change return.
    assign w_req        = d | (r != 3'd0);

    // Coins owed when a request is accepted: change plus the refund of the
    // price if the drink cannot be delivered. Max 7+5 = 12 fits in 4 bits.
    assign w_load_count = {1'b0, r} + ((d & empty) ? c_PRICE_COINS : 4'd0);

    assign w_count_dec  = count_q - 4'd1;
    assign w_timer_dec  = timer_q - 8'd1;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        count_d    = count_q;
        sold_out_d = 1'b0;
        // Any request outside IDLE (DONE included) is dropped and flagged.
        overrun_d  = w_req & (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                if (w_req) begin
                    count_d = w_load_count;
                    if (d && !empty) begin
                        state_d = S_MOTOR;
                        timer_d = c_MOTOR_RELOAD;
                    end else begin
                        // Either a sold-out refund (count >= 5) or a plain
                        // change return (r != 0): the count is never zero.
                        state_d    = S_PULSE;
                        timer_d    = c_PULSE_RELOAD;
                        sold_out_d = d & empty;
                    end
                end
            end

            S_MOTOR: begin
                if (timer_q == 8'd0) begin
                    if (count_q != 4'd0) begin
                        state_d = S_PULSE;
                        timer_d = c_PULSE_RELOAD;
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    timer_d = w_timer_dec;
                end
            end

            S_PULSE: begin
                if (timer_q == 8'd0) begin
                    count_d = w_count_dec;
                    if (w_count_dec != 4'd0) begin
                        state_d = S_GAP;
                        timer_d = c_GAP_RELOAD;
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    timer_d = w_timer_dec;
                end
            end

            S_GAP: begin
                if (timer_q == 8'd0) begin
                    state_d = S_PULSE;
                    timer_d = c_PULSE_RELOAD;
                end else begin
                    timer_d = w_timer_dec;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
                timer_d = 8'd0;
            end

            default: begin
                state_d = S_IDLE;
                timer_d = 8'd0;
                count_d = 4'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State and output registers. Actuator outputs are registered copies of
    // the decoded next state, so they line up exactly with state_q.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            timer_q    <= 8'd0;
            count_q    <= 4'd0;
            motor_q    <= 1'b0;
            hopper_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            sold_out_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            count_q    <= count_d;
            motor_q    <= (state_d == S_MOTOR);
            hopper_q   <= (state_d == S_PULSE);
            busy_q     <= (state_d != S_IDLE);
            done_q     <= (state_d == S_DONE);
            sold_out_q <= sold_out_d;
            overrun_q  <= overrun_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign motor        = motor_q;
    assign hopper       = hopper_q;
    assign busy         = busy_q;
    assign coin_inhibit = busy_q;
    assign done         = done_q;
    assign sold_out     = sold_out_q;
    assign overrun      = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_vend_dispense_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_vend_dispense_sequencer
// Description : Scoreboard bench for vend_dispense_sequencer. Stimulus pushes
//               the expected per-sequence summary (motor cycles, hopper
//               pulses, busy cycles, sold_out pulses) into a queue; a monitor
//               accumulates DUT activity and pops/compares on every done.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vend_dispense_sequencer;

    localparam int MOTOR = 4;
    localparam int PULSE = 2;
    localparam int GAP   = 2;

    logic       clk;
    logic       reset;
    logic       d;
    logic [2:0] r;
    logic       empty;
    logic       motor;
    logic       hopper;
    logic       busy;
    logic       coin_inhibit;
    logic       done;
    logic       sold_out;
    logic       overrun;

    vend_dispense_sequencer #(
        .MOTOR_CYCLES (MOTOR),
        .PULSE_CYCLES (PULSE),
        .GAP_CYCLES   (GAP)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .d            (d),
        .r            (r),
        .empty        (empty),
        .motor        (motor),
        .hopper       (hopper),
        .busy         (busy),
        .coin_inhibit (coin_inhibit),
        .done         (done),
        .sold_out     (sold_out),
        .overrun      (overrun)
    );

    typedef struct {
        int m;   // motor-high cycles
        int h;   // hopper pulses
        int b;   // busy cycles
        int s;   // sold_out pulses
    } exp_t;

    exp_t q[$];

    int n_checks;
    int n_pass;
    int exp_ovr;
    int ovr_seen;

    // monitor accumulators
    int mon_mc;
    int mon_hc;
    int mon_bc;
    int mon_sc;
    int mon_run;
    bit mon_ph;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic push(input int m, input int h, input int b, input int s);
        exp_t e;
        e.m = m; e.h = h; e.b = b; e.s = s;
        q.push_back(e);
    endtask

    // Drive a one-cycle request, then check first-cycle latency.
    task automatic req(input logic dd, input logic [2:0] rr, input logic ee,
                       input bit exp_motor, input int exp_sold, input string nm);
        @(posedge clk); #1;
        d = dd; r = rr; empty = ee;
        @(posedge clk); #1;
        d = 1'b0; r = 3'd0; empty = 1'b0;
        if (exp_motor) chk({nm, "_motor_latency"}, int'(motor), 1);
        else           chk({nm, "_hopper_latency"}, int'(hopper), 1);
        chk({nm, "_sold_out_pulse"}, int'(sold_out), exp_sold);
    endtask

    task automatic wait_done(input string nm);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 300 && !seen; k++) begin
            @(posedge clk); #1;
            seen = done;
        end
        if (!seen) begin
            n_checks++;
            $display("FAIL %s_timeout: done not seen within 300 cycles", nm);
        end
    endtask

    // ------------------------------------------------------------------------
    // Monitor / scoreboard
    // ------------------------------------------------------------------------
    initial begin
        exp_t e;
        mon_mc = 0; mon_hc = 0; mon_bc = 0; mon_sc = 0; mon_run = 0; mon_ph = 1'b0;
        ovr_seen = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                mon_mc = 0; mon_hc = 0; mon_bc = 0; mon_sc = 0;
                mon_run = 0; mon_ph = 1'b0;
            end else begin
                if (overrun) ovr_seen++;
                if (busy) begin
                    chk("inhibit_eq_busy", int'(coin_inhibit), int'(busy));
                    chk("motor_hopper_exclusive", int'(motor & hopper), 0);
                    mon_bc++;
                end
                if (motor)    mon_mc++;
                if (sold_out) mon_sc++;
                if (hopper) begin
                    if (!mon_ph) mon_hc++;
                    mon_run++;
                end else if (mon_ph) begin
                    chk("hopper_pulse_len", mon_run, PULSE);
                    mon_run = 0;
                end
                mon_ph = hopper;
                if (done) begin
                    if (q.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_done: got done with %0d pending expected", q.size());
                    end else begin
                        e = q.pop_front();
                        chk("seq_motor_cycles", mon_mc, e.m);
                        chk("seq_hopper_pulses", mon_hc, e.h);
                        chk("seq_busy_cycles", mon_bc, e.b);
                        chk("seq_sold_out", mon_sc, e.s);
                    end
                    mon_mc = 0; mon_hc = 0; mon_bc = 0; mon_sc = 0;
                end
            end
        end
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        n_checks = 0;
        n_pass   = 0;
        exp_ovr  = 0;
        reset    = 1'b1;
        d        = 1'b0;
        r        = 3'd0;
        empty    = 1'b0;

        #2;
        chk("reset_outputs", int'({motor, hopper, busy, coin_inhibit, done, sold_out, overrun}), 0);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("post_reset_outputs", int'({motor, hopper, busy, coin_inhibit, done, sold_out, overrun}), 0);

        // Drink only: 4 motor cycles + done = 5 busy
        push(4, 0, 5, 0);
        req(1'b1, 3'd0, 1'b0, 1'b1, 0, "drink_only");
        wait_done("drink_only");

        // Drink + 3 coins: 4 + 3*2 + 2*2 + 1 = 15
        push(4, 3, 15, 0);
        req(1'b1, 3'd3, 1'b0, 1'b1, 0, "drink_r3");
        wait_done("drink_r3");

        // Sold out with r=2: 7 coins, 7*2 + 6*2 + 1 = 27
        push(0, 7, 27, 1);
        req(1'b1, 3'd2, 1'b1, 1'b0, 1, "sold_out_r2");
        wait_done("sold_out_r2");

        // Request during 2nd motor cycle is dropped; empty ignored while busy
        push(4, 1, 7, 0);
        req(1'b1, 3'd1, 1'b0, 1'b1, 0, "overrun_base");
        @(posedge clk); #1;
        d = 1'b1; r = 3'd1; empty = 1'b1;
        exp_ovr++;
        @(posedge clk); #1;
        d = 1'b0; r = 3'd0; empty = 1'b0;
        wait_done("overrun_base");

        // Reset during the 2nd hopper pulse of an r=4 return
        req(1'b0, 3'd4, 1'b0, 1'b0, 0, "abort_r4");
        repeat (4) @(posedge clk);
        #1;
        chk("abort_second_pulse_hopper", int'(hopper), 1);
        reset = 1'b1;
        #1;
        chk("abort_outputs_zero", int'({motor, hopper, busy, coin_inhibit, done, sold_out, overrun}), 0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("abort_post_release_zero", int'({motor, hopper, busy, coin_inhibit, done, sold_out, overrun}), 0);
        push(0, 1, 3, 0);
        req(1'b0, 3'd1, 1'b0, 1'b0, 0, "after_abort_r1");
        wait_done("after_abort_r1");

        // Back-to-back: second request in the first IDLE cycle after done
        push(4, 0, 5, 0);
        req(1'b1, 3'd0, 1'b0, 1'b1, 0, "b2b_first");
        wait_done("b2b_first");
        push(4, 1, 7, 0);
        req(1'b1, 3'd1, 1'b0, 1'b1, 0, "b2b_second");
        wait_done("b2b_second");

        repeat (5) @(posedge clk);
        chk("scoreboard_drained", q.size(), 0);
        chk("overrun_count", ovr_seen, exp_ovr);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
